// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, arbiter state and load-buffer entry type
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_RA_W   = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_e;

  // Entry fields are sized to the package defaults; module widths must not exceed them.
  typedef struct packed {
    logic                 valid;
    logic                 kill;
    logic [WB_RA_W-1:0]   rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_ldq.sv
// rtl/wb_ldq.sv - load-return FIFO with per-entry kill on destination-register match
module wb_ldq
  import wb_pkg::*;
#(
  parameter  int DATA_W = WB_DATA_W,
  parameter  int RA_W   = WB_RA_W,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [RA_W-1:0]   push_rd_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [RA_W-1:0]   kill_rd_i,
  output logic              head_kill_o,
  output logic [RA_W-1:0]   head_rd_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // The push slot is never valid here, so a same-cycle push escapes the kill.
      if (kill_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem_q[i].valid && (mem_q[i].rd == WB_RA_W'(kill_rd_i))) mem_q[i].kill <= 1'b1;
        end
      end
      if (pop_i) begin
        mem_q[rd_ptr_q].valid <= 1'b0;
        mem_q[rd_ptr_q].kill  <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + PTR_W'(1);
      end
      if (push_i) begin
        mem_q[wr_ptr_q] <= '{valid: 1'b1, kill: 1'b0,
                             rd: WB_RA_W'(push_rd_i), data: WB_DATA_W'(push_data_i)};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_kill_o = mem_q[rd_ptr_q].kill;
  assign head_rd_o   = mem_q[rd_ptr_q].rd[RA_W-1:0];
  assign head_data_o = mem_q[rd_ptr_q].data[DATA_W-1:0];
  assign count_o     = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - single register-file write port shared by ALU results and load returns
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int RA_W   = WB_RA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [RA_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  input  logic [RA_W-1:0]   ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              stall,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_state_e          state;
  logic [CNT_W-1:0]   count;
  logic               ld_acc, grant_alu, bypass, push, pop, kill;
  logic               head_kill;
  logic [RA_W-1:0]    head_rd;
  logic [DATA_W-1:0]  head_data;

  wb_ldq #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH)) u_ldq (
    .clock       (clock),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_rd_i   (ld_rd),
    .push_data_i (ld_data),
    .pop_i       (pop),
    .kill_i      (kill),
    .kill_rd_i   (alu_rd),
    .head_kill_o (head_kill),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .count_o     (count)
  );

  always_comb begin
    if (count == '0)                 state = ST_EMPTY;
    else if (count == CNT_W'(DEPTH)) state = ST_FULL;
    else                             state = ST_PEND;
  end

  assign ld_ready = (state != ST_FULL);
  assign ld_acc   = ld_valid && ld_ready;

  always_comb begin
    grant_alu = 1'b0;
    bypass    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    stall     = 1'b0;
    // Nothing is granted while reset is held, so no write can leak out of it.
    if (rst_n) begin
      case (state)
        ST_EMPTY: begin
          if (alu_valid) begin
            grant_alu = 1'b1;
            push      = ld_acc && (ld_rd != '0);
          end else begin
            bypass    = ld_acc;
          end
        end
        ST_PEND: begin
          grant_alu = alu_valid;
          pop       = !alu_valid;
          push      = ld_acc && (ld_rd != '0);
        end
        ST_FULL: begin
          stall = alu_valid;
          pop   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign kill = grant_alu && (alu_rd != '0);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (grant_alu) begin
      if (alu_rd != '0) begin
        rf_we    = 1'b1;
        rf_waddr = alu_rd;
        rf_wdata = alu_data;
      end
    end else if (bypass) begin
      if (ld_rd != '0) begin
        rf_we    = 1'b1;
        rf_waddr = ld_rd;
        rf_wdata = ld_data;
      end
    end else if (pop && !head_kill) begin
      rf_we    = 1'b1;
      rf_waddr = head_rd;
      rf_wdata = head_data;
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register-file write-data width.
REQ-002 SHALL have parameter RA_W, default 5, register-address width.
REQ-003 SHALL have parameter DEPTH, default 2, load-return buffer entries (power of 2, >=2).
REQ-004 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: alu_valid  in  1  ALU-path writeback request this cycle.
REQ-007 SHALL have port: alu_rd  in  RA_W  ALU-path destination register.
REQ-008 SHALL have port: alu_data  in  DATA_W  ALU result.
REQ-009 SHALL have port: ld_valid  in  1  load-return data valid.
REQ-010 SHALL have port: ld_rd  in  RA_W  load destination register.
REQ-011 SHALL have port: ld_data  in  DATA_W  load return data.
REQ-012 SHALL have port: ld_ready  out  1  buffer can accept a load return; high when count < DEPTH.
REQ-013 SHALL have port: stall  out  1  ALU path must hold its request; combinational.
REQ-014 SHALL have port: rf_we  out  1  register-file write enable.
REQ-015 SHALL have port: rf_waddr  out  RA_W  register-file write address.
REQ-016 SHALL have port: rf_wdata  out  DATA_W  register-file write data.

Function
REQ-017 SHALL grant the single register-file write port to exactly one source per cycle: ALU, buffer head, or bypassed load.
REQ-018 SHALL use a state machine EMPTY / PEND / FULL, derived from count (0 / 1..DEPTH-1 / DEPTH).
REQ-019 In EMPTY, SHALL grant alu_valid to the ALU and enqueue a simultaneous load; with no alu_valid it SHALL write ld_valid data directly (zero-latency bypass, no enqueue).
REQ-020 In PEND, SHALL grant alu_valid to the ALU; otherwise it SHALL write and pop the buffer head. A simultaneous ld_valid SHALL be enqueued.
REQ-021 In FULL, SHALL assert stall when alu_valid=1 and SHALL write and pop the buffer head regardless of alu_valid; ld_ready=0.
REQ-022 Buffer SHALL be FIFO-ordered; push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 A load with ld_valid=1 while ld_ready=0 SHALL be ignored (protocol violation, no state change).
REQ-024 Requests with rd=0 SHALL be accepted but never produce rf_we=1 and SHALL not be enqueued.
REQ-025 When the ALU is granted a write to rd equal to a valid buffer entry's rd, that entry SHALL be killed; when popped, a killed entry SHALL drain with rf_we=0 (WAW protection).
REQ-026 A load enqueued in the same cycle as an ALU write to the same rd SHALL NOT be killed (the load is architecturally younger).
REQ-027 rf_we, rf_waddr, rf_wdata SHALL be combinational from the grant; rf_waddr/rf_wdata SHALL be 0 when rf_we=0.
REQ-028 Latency: ALU write 0 cycles; load 0 cycles if bypassed, else dequeued on the first cycle without ALU grant or in FULL.

Reset
REQ-029 rst_n low SHALL asynchronously clear count, pointers, and all entry valid/kill bits; state=EMPTY.
REQ-030 During and immediately after reset: rf_we=0, stall=0, ld_ready=1; in-flight buffer contents SHALL be discarded.

Structure
REQ-031 Shared package wb_pkg SHALL hold DATA_W/RA_W defaults, state enum (EMPTY, PEND, FULL), and entry struct {valid, kill, rd, data}.
REQ-032 Buffer storage and pointers SHALL be a sub-module wb_ldq (push, pop, head, count, rd-match kill); arbitration stays in wb_arbiter.

Verification
REQ-033 Empty, ld_valid rd=5 data=0xA5A5A5A5, alu_valid=0 -> same cycle rf_we=1, waddr=5, wdata=0xA5A5A5A5; count stays 0.
REQ-034 alu_valid rd=3 data=1 with ld_valid rd=4 data=2 -> cycle0 write r3=1; next idle cycle write r4=2.
REQ-035 Two loads buffered under continuous alu_valid -> FULL, ld_ready=0; next cycle stall=1, head written, ALU write deferred until stall=0.
REQ-036 Buffered load rd=7, then ALU write rd=7 data=9 -> r7=9 written; popped entry gives rf_we=0; r7 remains 9.
REQ-037 Load and ALU both rd=0 -> rf_we never asserts; count unchanged.
REQ-038 rst_n low with count=2 for one cycle mid-drain -> count=0, ld_ready=1, rf_we=0; no stale write after release.
